drum_strike_detector: RTL and testbench

- Downstream consumer of the BNO085 controller's quaternion and gyro outputs in the drum-set datapath.
- Detects a downward stick swing followed by impact deceleration on the gyro Y axis.
- Emits one single-cycle hit event with a 7-bit velocity and a 2-bit drum zone; the zone comes from the latest quaternion Z (yaw proxy).
- Runs on the 3 MHz system clock. Feeds the drum-set sound/trigger logic.

---
 rtl/drum_strike_detector.sv | 163 ++++++++++++++++
 tb/tb_drum_strike_detector.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/drum_strike_detector.sv
// Drum strike detector: turns a downward gyro-Y swing plus its impact deceleration into one hit event.
// Optional input smoothing (two-sample average of gyro_y) is enabled by defining STRIKE_SMOOTH_EN.
module drum_strike_detector #(
    parameter int SWING_THRESH      = 2000,
    parameter int RELEASE_THRESH    = 500,
    parameter int VEL_SHIFT         = 7,
    parameter int HOLDOFF_CYCLES    = 300000,
    parameter int MAX_SWING_SAMPLES = 200,
    parameter int ZONE_THRESH       = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               gyro_valid,
    input  logic signed [15:0] gyro_y,
    input  logic               quat_valid,
    input  logic signed [15:0] quat_z,
    output logic               hit_valid,
    output logic [6:0]         hit_velocity,
    output logic [1:0]         hit_zone,
    output logic               swing_active,
    output logic [1:0]         zone_now
);

    localparam int HO_W = ($clog2(HOLDOFF_CYCLES) < 19) ? 19 : $clog2(HOLDOFF_CYCLES);
    localparam int SC_W = $clog2(MAX_SWING_SAMPLES + 1);

    localparam logic [15:0]        SWING_T   = 16'(SWING_THRESH);
    localparam logic [15:0]        RELEASE_T = 16'(RELEASE_THRESH);
    localparam logic [SC_W-1:0]    MAX_SAMP  = SC_W'(MAX_SWING_SAMPLES);
    localparam logic [HO_W-1:0]    HOLD_LAST = HO_W'(HOLDOFF_CYCLES - 1);
    localparam logic signed [15:0] ZONE_HI   = 16'(ZONE_THRESH);
    localparam logic signed [15:0] ZONE_LO   = -ZONE_HI;

    typedef enum logic [1:0] {IDLE, SWING, HOLDOFF} state_t;

    state_t             state;
    logic signed [15:0] quat_z_q;
    logic [15:0]        peak;
    logic [SC_W-1:0]    sample_cnt;
    logic [HO_W-1:0]    holdoff_cnt;

    logic signed [16:0] y_f;
    logic signed [16:0] neg_y;
    logic [15:0]        mag;
    logic [15:0]        peak_shifted;
    logic [6:0]         vel_c;
    logic [1:0]         zone_c;

`ifdef STRIKE_SMOOTH_EN
    logic signed [15:0] prev_gyro_y;
    logic signed [16:0] sum_y;

    assign sum_y = {gyro_y[15], gyro_y} + {prev_gyro_y[15], prev_gyro_y};
    assign y_f   = sum_y >>> 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            prev_gyro_y <= '0;
        else if (gyro_valid)
            prev_gyro_y <= gyro_y;
    end
`else
    assign y_f = {gyro_y[15], gyro_y};
`endif

    // Downward magnitude; the single unrepresentable negation (-32768) saturates.
    always_comb begin
        neg_y = -y_f;
        mag   = 16'd0;
        if (y_f[16])
            mag = (y_f == -17'sd32768) ? 16'h7FFF : neg_y[15:0];
    end

    always_comb begin
        peak_shifted = peak >> VEL_SHIFT;
        if (peak_shifted > 16'd127)
            vel_c = 7'd127;
        else if (peak_shifted == 16'd0)
            vel_c = 7'd1;
        else
            vel_c = peak_shifted[6:0];
    end

    always_comb begin
        if (quat_z_q < ZONE_LO)
            zone_c = 2'd0;
        else if (quat_z_q > ZONE_HI)
            zone_c = 2'd2;
        else
            zone_c = 2'd1;
    end

    assign zone_now = zone_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            quat_z_q <= '0;
        else if (quat_valid)
            quat_z_q <= quat_z;
    end

    // hit_zone samples zone_c before this edge, so a quaternion arriving with the release sample only affects later hits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            peak         <= '0;
            sample_cnt   <= '0;
            holdoff_cnt  <= '0;
            hit_valid    <= 1'b0;
            hit_velocity <= '0;
            hit_zone     <= 2'd1;
            swing_active <= 1'b0;
        end else begin
            hit_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (gyro_valid && mag >= SWING_T) begin
                        state        <= SWING;
                        peak         <= mag;
                        sample_cnt   <= SC_W'(1);
                        swing_active <= 1'b1;
                    end
                end
                SWING: begin
                    if (gyro_valid) begin
                        if (mag < RELEASE_T) begin
                            state        <= HOLDOFF;
                            holdoff_cnt  <= '0;
                            hit_valid    <= 1'b1;
                            hit_velocity <= vel_c;
                            hit_zone     <= zone_c;
                            swing_active <= 1'b0;
                        end else if (sample_cnt == MAX_SAMP) begin
                            state        <= IDLE;
                            peak         <= '0;
                            sample_cnt   <= '0;
                            swing_active <= 1'b0;
                        end else begin
                            if (mag > peak)
                                peak <= mag;
                            sample_cnt <= sample_cnt + SC_W'(1);
                        end
                    end
                end
                HOLDOFF: begin
                    if (holdoff_cnt == HOLD_LAST) begin
                        state       <= IDLE;
                        holdoff_cnt <= '0;
                        peak        <= '0;
                        sample_cnt  <= '0;
                    end else begin
                        holdoff_cnt <= holdoff_cnt + HO_W'(1);
                    end
                end
                default: begin
                    state        <= IDLE;
                    swing_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drum_strike_detector.sv
// Randomized and directed bench for drum_strike_detector against a cycle-level behavioural model.
// Holdoff is shortened to keep the run short; build with STRIKE_SMOOTH_EN to exercise the smoothing path.
module tb_drum_strike_detector;

    localparam int HOLD = 300;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               gyro_valid = 1'b0;
    logic signed [15:0] gyro_y = '0;
    logic               quat_valid = 1'b0;
    logic signed [15:0] quat_z = '0;
    logic               hit_valid;
    logic [6:0]         hit_velocity;
    logic [1:0]         hit_zone;
    logic               swing_active;
    logic [1:0]         zone_now;

    int errors = 0;
    int checks = 0;

    // Reference model state: plain integers and an absolute "ignore samples until" edge number.
    int     m_q, m_prev, m_peak, m_nsamp;
    bit     m_in_swing;
    longint edge_n = 0;
    longint hold_end = -1;
    int     e_hit, e_vel, e_zone, e_swing, e_znow;
    int     hit_count = 0;

    drum_strike_detector #(.HOLDOFF_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst),
        .gyro_valid(gyro_valid), .gyro_y(gyro_y),
        .quat_valid(quat_valid), .quat_z(quat_z),
        .hit_valid(hit_valid), .hit_velocity(hit_velocity), .hit_zone(hit_zone),
        .swing_active(swing_active), .zone_now(zone_now)
    );

    always #5 clk = ~clk;

    function automatic int zoneOf(input int q);
        if (q < -4096) return 0;
        if (q > 4096) return 2;
        return 1;
    endfunction

    function automatic int magOf(input int y);
        if (y >= 0) return 0;
        return (-y > 32767) ? 32767 : -y;
    endfunction

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: got %0d expected %0d", tag, edge_n, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_q = 0; m_prev = 0; m_peak = 0; m_nsamp = 0; m_in_swing = 0;
        hold_end = -1;
        e_hit = 0; e_vel = 0; e_zone = 1; e_swing = 0; e_znow = 1;
    endtask

    task automatic modelEdge(input bit gv, input int gy, input bit qv, input int qz);
        int y, m, zone_before;
        edge_n++;
        zone_before = zoneOf(m_q);
        e_hit = 0;
        if (gv) begin
`ifdef STRIKE_SMOOTH_EN
            y = (gy + m_prev) >>> 1;
            m_prev = gy;
`else
            y = gy;
`endif
            m = magOf(y);
            if (edge_n > hold_end) begin
                if (!m_in_swing) begin
                    if (m >= 2000) begin
                        m_in_swing = 1; m_peak = m; m_nsamp = 1;
                    end
                end else if (m < 500) begin
                    m_in_swing = 0;
                    e_hit = 1;
                    e_vel = m_peak >> 7;
                    if (e_vel > 127) e_vel = 127;
                    if (e_vel == 0) e_vel = 1;
                    e_zone = zone_before;
                    hold_end = edge_n + HOLD;
                end else if (m_nsamp == 200) begin
                    m_in_swing = 0; m_peak = 0;
                end else begin
                    if (m > m_peak) m_peak = m;
                    m_nsamp++;
                end
            end
        end
        if (qv) m_q = qz;
        e_znow = zoneOf(m_q);
        e_swing = m_in_swing;
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".hit_valid"}, int'(hit_valid), e_hit);
        checkOutput({tag, ".hit_velocity"}, int'(hit_velocity), e_vel);
        checkOutput({tag, ".hit_zone"}, int'(hit_zone), e_zone);
        checkOutput({tag, ".swing_active"}, int'(swing_active), e_swing);
        checkOutput({tag, ".zone_now"}, int'(zone_now), e_znow);
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare #1 later.
    task automatic applyStimulus(input bit gv, input int gy, input bit qv, input int qz);
        gyro_valid = gv;
        gyro_y     = 16'(gy);
        quat_valid = qv;
        quat_z     = 16'(qz);
        @(posedge clk);
        modelEdge(gv, gy, qv, qz);
        #1;
        if (hit_valid === 1'b1) hit_count++;
        checkAll("step");
    endtask

    task automatic sample(input int gy);
        applyStimulus(1'b1, gy, 1'b0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, 0);
    endtask

    task automatic resetPulse();
        rst = 1'b1;
        #2;
        modelReset();
        checkAll("reset");
        #1;
        rst = 1'b0;
    endtask

    task automatic swingCase1();
        sample(0); sample(-2500); sample(-8000); sample(-12800); sample(-3000); sample(-400);
    endtask

    int h0, gy_r;

    initial begin
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkAll("por");
        rst = 1'b0;

`ifndef STRIKE_SMOOTH_EN
        // Basic swing and release: peak 12800 gives velocity 100 in the centre zone.
        swingCase1();
        checkOutput("tp1_hit", int'(hit_valid), 1);
        checkOutput("tp1_vel", int'(hit_velocity), 100);
        idle(HOLD + 2);

        // Saturated sample.
        sample(-4000); sample(-32768); sample(-100);
        checkOutput("tp2_vel", int'(hit_velocity), 127);
        idle(HOLD + 2);
`else
        // Smoothed samples -2000, -4000, -2000, 0: hit on the fourth with velocity 31.
        sample(-4000); sample(-4000); sample(0); sample(0);
        checkOutput("sm_hit", int'(hit_valid), 1);
        checkOutput("sm_vel", int'(hit_velocity), 31);
        idle(HOLD + 2);
        swingCase1();
        idle(HOLD + 2);
`endif

        // Zone latched before the release sample; a concurrent quaternion only shows on zone_now.
        applyStimulus(1'b0, 0, 1'b1, -5000);
        sample(0); sample(-2500); sample(-8000); sample(-12800); sample(-3000);
        applyStimulus(1'b1, -400, 1'b1, 5000);
        idle(HOLD + 2);

        // Holdoff: a swing shortly after a hit is ignored, one after the window is seen.
        swingCase1();
        h0 = hit_count;
        idle(100);
        swingCase1();
        checkOutput("holdoff_blocks", hit_count, h0);
        idle(HOLD - 100);
        sample(-2500); sample(-9000); sample(-400);
        checkOutput("holdoff_expired", hit_count, h0 + 1);
        idle(HOLD + 2);

        // Timeout after MAX_SWING_SAMPLES, then a lone release sample.
        h0 = hit_count;
        sample(-2500);
        for (int i = 0; i < 200; i++) sample(-3000);
        sample(-400);
        idle(3);
        checkOutput("timeout_nohit", hit_count, h0);

        // Reset in the middle of a swing.
        sample(-2500); sample(-8000);
        resetPulse();
        sample(-400);
        idle(2);
        checkOutput("reset_nohit", hit_count, h0);

        // Randomized traffic.
        for (int i = 0; i < 6000; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    gy_r = int'($urandom_range(0, 3000));
                2:       gy_r = -int'($urandom_range(0, 499));
                3:       gy_r = -int'($urandom_range(500, 1999));
                9:       gy_r = -32768;
                default: gy_r = -int'($urandom_range(2000, 20000));
            endcase
            applyStimulus($urandom_range(0, 3) != 0, gy_r,
                          $urandom_range(0, 7) == 0, int'($urandom_range(0, 16000)) - 8000);
            if ($urandom_range(0, 1999) == 0) resetPulse();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
